// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit issue/writeback sequencer:
// opcode encodings, FSM state type and the default datapath sizes.
package lu_pkg;

    localparam int LU_DATA_W = 16;
    localparam int LU_REG_N  = 8;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_NAND = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_XNOR = 4'b1110;
    localparam logic [3:0] OP_NEG  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    // Every opcode with the top bit set is handled by the logic unit.
    function automatic logic is_logic_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/lu_regfile.sv
// Operand register file: one synchronous write port, three combinational
// read ports (two operands plus debug). Clears to zero on reset.
module lu_regfile
    import lu_pkg::*;
#(
    parameter int DATA_W = LU_DATA_W,
    parameter int REG_N  = LU_REG_N,
    parameter int RA_W   = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RA_W-1:0]   i_ra_addr,
    input  logic [RA_W-1:0]   i_rb_addr,
    input  logic [RA_W-1:0]   i_dbg_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [REG_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data  = r_mem[i_ra_addr];
    assign o_rb_data  = r_mem[i_rb_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/lu_sequencer.sv
// Issue/writeback sequencer in front of the 16-bit logic unit.
// Optional perf counters are built when LU_SEQ_PERF_EN is defined.
module lu_sequencer
    import lu_pkg::*;
#(
    parameter int DATA_W = LU_DATA_W,
    parameter int REG_N  = LU_REG_N,
    parameter int RA_W   = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [RA_W-1:0]   instr_rd,
    input  logic [RA_W-1:0]   instr_ra,
    input  logic [RA_W-1:0]   instr_rb,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [3:0]        lu_opcode,
    output logic [DATA_W-1:0] lu_a,
    output logic [DATA_W-1:0] lu_b,
    input  logic [DATA_W-1:0] lu_result,
    input  logic              lu_sel,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [RA_W-1:0]   res_rd,
    output logic              err,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`ifdef LU_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_instr_cnt,
    output logic [15:0]       perf_zero_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_instr_ready;
    logic              w_legal;
    logic              w_accept;
    logic              w_we;
    logic              w_zero;
    logic [DATA_W-1:0] w_ra_data;
    logic [DATA_W-1:0] w_rb_data;
    logic [DATA_W-1:0] w_value;

    logic [3:0]        r_lu_opcode;
    logic [DATA_W-1:0] r_lu_a;
    logic [DATA_W-1:0] r_lu_b;
    logic [DATA_W-1:0] r_imm;
    logic [RA_W-1:0]   r_rd;
    logic              r_is_load;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_zero;
    logic [RA_W-1:0]   r_res_rd;
    logic              r_err;

    assign w_legal  = is_logic_op(instr_op) || (instr_op == OP_LOAD);
    assign w_accept = instr_valid && w_instr_ready;
    assign w_we     = (r_state == EXEC);
    assign w_value  = r_is_load ? r_imm : lu_result;
    // The logic unit's own zero flag is trusted for logic ops.
    assign w_zero   = r_is_load ? (r_imm == '0) : lu_sel;

    lu_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_rd),
        .i_wdata    (w_value),
        .i_ra_addr  (instr_ra),
        .i_rb_addr  (instr_rb),
        .i_dbg_addr (dbg_addr),
        .o_ra_data  (w_ra_data),
        .o_rb_data  (w_rb_data),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_instr_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_instr_ready = 1'b1;
                if (instr_valid && w_legal) begin
                    w_state_next = EXEC;
                end
            end
            EXEC:    w_state_next = HOLD;
            HOLD: begin
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_opcode <= '0;
            r_lu_a      <= '0;
            r_lu_b      <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_is_load   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_rd    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_rd      <= instr_rd;
                r_imm     <= instr_imm;
                r_is_load <= !is_logic_op(instr_op);
                // Operands are sampled here, so ra==rd still sees the old value.
                if (is_logic_op(instr_op)) begin
                    r_lu_opcode <= instr_op;
                    r_lu_a      <= w_ra_data;
                    r_lu_b      <= w_rb_data;
                end else begin
                    r_lu_opcode <= OP_LOAD;
                    r_lu_a      <= '0;
                    r_lu_b      <= '0;
                end
            end
            if (r_state == EXEC) begin
                r_res_valid <= 1'b1;
                r_res_data  <= w_value;
                r_res_zero  <= w_zero;
                r_res_rd    <= r_rd;
            end else if ((r_state == HOLD) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef LU_SEQ_PERF_EN
    logic [15:0] r_perf_instr_cnt;
    logic [15:0] r_perf_zero_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_instr_cnt <= '0;
            r_perf_zero_cnt  <= '0;
        end else if (r_state == EXEC) begin
            if (r_perf_instr_cnt != 16'hFFFF) begin
                r_perf_instr_cnt <= r_perf_instr_cnt + 16'd1;
            end
            if (w_zero && (r_perf_zero_cnt != 16'hFFFF)) begin
                r_perf_zero_cnt <= r_perf_zero_cnt + 16'd1;
            end
        end
    end

    assign perf_instr_cnt = r_perf_instr_cnt;
    assign perf_zero_cnt  = r_perf_zero_cnt;
`endif

    assign instr_ready = w_instr_ready;
    assign lu_opcode   = r_lu_opcode;
    assign lu_a        = r_lu_a;
    assign lu_b        = r_lu_b;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_zero    = r_res_zero;
    assign res_rd      = r_res_rd;
    assign err         = r_err;

endmodule

// File: doc/lu_sequencer.md
Name: lu_sequencer

Overview:
- Issue and writeback stage directly upstream of the 16-bit logic unit (opcodes 1000-1111, Result plus zero flag Sel).
- Accepts instructions on a valid/ready port and reads operands from a local 8x16 register file.
- Drives registered Opcode/A/B into the logic unit and captures Result/Sel into the destination register.
- Presents each result on a valid/ready output port.

Parameters:
- DATA_W, 16, operand/result width; must match the logic unit.
- REG_N, 8, register file depth.
- RA_W, 3, register address width, clog2(REG_N).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  4  0000=LOAD imm; 1000-1111 logic ops; all others illegal.
- instr_rd, instr_ra, instr_rb  in  RA_W each  destination and source registers.
- instr_imm  in  DATA_W  immediate, used by LOAD only.
- lu_opcode  out  4  to logic unit Opcode.
- lu_a, lu_b  out  DATA_W  to logic unit A and B.
- lu_result  in  DATA_W  from logic unit Result.
- lu_sel  in  1  from logic unit Sel (zero flag).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DATA_W  written value.
- res_zero  out  1  zero flag of the written value.
- res_rd  out  RA_W  destination register of the result.
- err  out  1  one-cycle pulse on an illegal opcode.
- dbg_addr  in  RA_W  debug read address.
- dbg_data  out  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (already decided): one clock; reset is asynchronous and active-low.
- rst_n low clears: FSM to IDLE, all registers to 0, lu_opcode/lu_a/lu_b to 0, res_valid/res_data/res_zero/res_rd to 0, err to 0.
  - lu_opcode=0000 makes the logic unit output Result 0, Sel 0.
- Reset mid-operation aborts the instruction. No partial write survives.
- FSM states: IDLE, EXEC, HOLD.
  - instr_ready = 1 only in IDLE.
- IDLE, on instr_valid & instr_ready:
  - Logic op: lu_opcode<=instr_op, lu_a<=reg[ra], lu_b<=reg[rb], latch rd; go to EXEC.
  - LOAD: lu_opcode<=0000, latch imm and rd; go to EXEC.
  - Illegal opcode: err=1 for that cycle, no write, no result, stay IDLE.
- EXEC (one cycle):
  - Write value into reg[rd]. Value is lu_result for logic ops, imm for LOAD.
  - Set res_data=value, res_zero=(value==0), res_rd=rd, res_valid<=1.
  - For logic ops, res_zero equals lu_sel.
  - Go to HOLD.
- HOLD: res_valid=1 and res_* held stable.
  - On res_ready: res_valid<=0, go to IDLE.
- Latency:
  - Accept edge to regfile write edge: 1 cycle.
  - res_valid rises 1 cycle after accept.
  - Minimum 3 cycles per instruction.
- Source equals destination (ra==rd): operands are sampled at accept, so the old value is used.
- NOT and NEG ignore rb. NEG is two's complement, wraps mod 2^16 (NEG 0x0000 = 0x0000, zero=1).
- rd=0 is an ordinary register, not hardwired to zero.
- Debug read (dbg_data) shows the new value the cycle after the write edge.
- instr_* inputs are ignored outside IDLE; no buffering.

Optional Feature:
- Macro: LU_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_instr_cnt[15:0] (completed LOAD and logic instructions) and perf_zero_cnt[15:0] (results with res_zero=1).
  - Both increment at the EXEC edge, saturate at 0xFFFF, and clear on reset.
  - Illegal opcodes are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package lu_pkg:
  - Opcode constants OP_LOAD=0000, AND=1000, NAND=1001, NOR=1010, OR=1011, NOT=1100, XOR=1101, XNOR=1110, NEG=1111.
  - Function is_logic_op(op) = op[3].
  - FSM state enum {IDLE, EXEC, HOLD}.
  - DATA_W default.
- Sub-module lu_regfile:
  - REG_N x DATA_W, asynchronous active-low reset to 0.
  - One synchronous write port.
  - Three combinational read ports (ra, rb, dbg).

Test Plan:
- LOAD r1=0x00FF, LOAD r2=0x0F0F, then AND r3,r1,r2 -> res_data=0x000F, res_zero=0, res_rd=3; dbg_addr=3 reads 0x000F.
- XOR r4,r1,r1 -> res_data=0x0000, res_zero=1; NEG r5,r1 -> res_data=0xFF01, res_zero=0; NOR r6,r1,r2 -> 0xF000.
- instr_op=0011 offered in IDLE -> err=1 for exactly one cycle, res_valid stays 0, regfile unchanged, instr_ready stays 1.
- res_ready held low 3 cycles after EXEC -> res_valid/res_data stable, instr_ready=0 throughout; res_ready=1 -> returns to IDLE next cycle.
- rst_n asserted while in HOLD -> immediately res_valid=0, instr_ready=1 after release, all registers read 0x0000 via dbg.
- With LU_SEQ_PERF_EN: the sequence above gives perf_instr_cnt=6 and perf_zero_cnt=1 (the XOR result only); the illegal opcode is not counted.
